// File: rtl/alu_issue_ctrl.sv
// Issue-side ALU front end: accepts an instruction, reads its sources over one RF port,
// issues control/operands for one cycle and captures the branch decision.
// Optional macro ALU_ISSUE_CNT_EN adds a free-running ISSUE_CNT output counting issues.
module alu_issue_ctrl #(
    parameter int          RF_LAT      = 1,
    parameter logic [5:0]  RTYPE_CLASS = 6'b000011
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    input  logic [31:0] INSTR,
    output logic        RF_SEL,
    output logic [4:0]  RF_RADDR,
    input  logic [31:0] RF_RDATA,
    output logic [11:0] ALU_CTRL,
    output logic [31:0] ALU_OP1,
    output logic [31:0] ALU_OP2,
    output logic [31:0] ALU_MSG1,
    output logic [31:0] ALU_MSG2,
    output logic        ALU_ISSUE,
    input  logic        ALU_ZF,
    output logic        RES_VALID,
    output logic        BR_TAKEN
`ifdef ALU_ISSUE_CNT_EN
    ,
    output logic [31:0] ISSUE_CNT
`endif
);

    // The read schedule below assumes data returns exactly one cycle after the address.
    if (RF_LAT != 1) begin : g_rf_lat_check
        $error("alu_issue_ctrl: only RF_LAT == 1 is supported");
    end

    typedef enum logic [2:0] {
        IDLE,
        RDA,
        RDA_HI,
        RDB,
        RDB_HI,
        CAPB,
        ISSUE,
        RES
    } state_t;

    state_t state, next_state;

    logic [31:0] instr_q;
    logic [31:0] a_lo_q;
    logic [31:0] a_hi_q;
    logic [31:0] b_lo_q;
    logic        br_q;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic        is_fp;
    logic        is_double;
    logic        is_branch;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    logic [4:0]  addr_a;
    logic [4:0]  addr_b;
    logic        accept;

    logic [11:0] ctrl_d;
    logic [31:0] op1_d;
    logic [31:0] op2_d;
    logic [31:0] msg1_d;
    logic [31:0] msg2_d;
    logic [31:0] b_lo_now;

    assign opcode    = instr_q[31:26];
    assign funct     = instr_q[5:0];
    assign shamt     = instr_q[10:6];
    assign imm       = instr_q[15:0];
    assign is_fp     = (opcode == 6'h11);
    assign is_double = is_fp && (instr_q[25:21] == 5'h11);
    assign is_branch = (opcode == 6'h04) || (opcode == 6'h05);
    assign src_a     = is_fp ? instr_q[15:11] : instr_q[25:21];
    assign src_b     = instr_q[20:16];
    // Double-precision pairs start on the even register; the odd partner holds the high word.
    assign addr_a    = is_double ? {src_a[4:1], 1'b0} : src_a;
    assign addr_b    = is_double ? {src_b[4:1], 1'b0} : src_b;
    assign accept    = (state == IDLE) && INSTR_VALID;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    next_state = INSTR_VALID ? RDA : IDLE;
            RDA:     next_state = is_double ? RDA_HI : RDB;
            RDA_HI:  next_state = RDB;
            RDB:     next_state = is_double ? RDB_HI : CAPB;
            RDB_HI:  next_state = CAPB;
            CAPB:    next_state = ISSUE;
            ISSUE:   next_state = RES;
            RES:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        INSTR_READY = (state == IDLE);
        ALU_ISSUE   = (state == ISSUE);
        RES_VALID   = (state == RES);
        RF_SEL      = 1'b0;
        RF_RADDR    = 5'd0;
        unique case (state)
            RDA: begin
                RF_SEL   = is_fp;
                RF_RADDR = addr_a;
            end
            RDA_HI: begin
                RF_SEL   = is_fp;
                RF_RADDR = {addr_a[4:1], 1'b1};
            end
            RDB: begin
                RF_SEL   = is_fp;
                RF_RADDR = addr_b;
            end
            RDB_HI: begin
                RF_SEL   = is_fp;
                RF_RADDR = {addr_b[4:1], 1'b1};
            end
            default: begin
                RF_SEL   = 1'b0;
                RF_RADDR = 5'd0;
            end
        endcase
        BR_TAKEN = br_q;
    end

    // Every read slot is taken even if the instruction ignores that source.
    always_ff @(posedge CLK) begin
        if (RST) begin
            instr_q <= 32'd0;
            a_lo_q  <= 32'd0;
            a_hi_q  <= 32'd0;
            b_lo_q  <= 32'd0;
        end else begin
            if (accept) begin
                instr_q <= INSTR;
            end
            unique case (state)
                RDA_HI: a_lo_q <= RF_RDATA;
                RDB: begin
                    if (is_double) begin
                        a_hi_q <= RF_RDATA;
                    end else begin
                        a_lo_q <= RF_RDATA;
                    end
                end
                RDB_HI:  b_lo_q <= RF_RDATA;
                default: ;
            endcase
        end
    end

    // In CAPB the last read's data is still on RF_RDATA and feeds the operand registers directly.
    always_comb begin
        b_lo_now = is_double ? b_lo_q : RF_RDATA;
        ctrl_d   = {opcode, 6'b0};
        op1_d    = a_lo_q;
        op2_d    = {{16{imm[15]}}, imm};
        msg1_d   = 32'd0;
        msg2_d   = 32'd0;
        unique case (opcode)
            6'h00: begin
                ctrl_d = {RTYPE_CLASS, funct};
                if ((funct == 6'h00) || (funct == 6'h02) || (funct == 6'h03)) begin
                    op1_d = b_lo_now;
                    op2_d = {27'd0, shamt};
                end else begin
                    op2_d = b_lo_now;
                end
            end
            6'h04, 6'h05: op2_d = b_lo_now;
            6'h0c, 6'h0e: op2_d = {16'd0, imm};
            6'h0f: begin
                op1_d = 32'd0;
                op2_d = {16'd0, imm};
            end
            6'h11: begin
                ctrl_d = {6'h11, funct};
                op2_d  = b_lo_now;
                if (is_double) begin
                    msg1_d = a_hi_q;
                    msg2_d = RF_RDATA;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ALU_CTRL <= 12'd0;
            ALU_OP1  <= 32'd0;
            ALU_OP2  <= 32'd0;
            ALU_MSG1 <= 32'd0;
            ALU_MSG2 <= 32'd0;
        end else if (state == CAPB) begin
            ALU_CTRL <= ctrl_d;
            ALU_OP1  <= op1_d;
            ALU_OP2  <= op2_d;
            ALU_MSG1 <= msg1_d;
            ALU_MSG2 <= msg2_d;
        end else if (state == RES) begin
            ALU_CTRL <= 12'd0;
            ALU_OP1  <= 32'd0;
            ALU_OP2  <= 32'd0;
            ALU_MSG1 <= 32'd0;
            ALU_MSG2 <= 32'd0;
        end
    end

    // Zero flag sampled at the end of the issue cycle, so the decision is visible only in RES.
    always_ff @(posedge CLK) begin
        if (RST) begin
            br_q <= 1'b0;
        end else begin
            br_q <= (state == ISSUE) && is_branch && ALU_ZF;
        end
    end

`ifdef ALU_ISSUE_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            ISSUE_CNT <= 32'd0;
        end else if (state == ISSUE) begin
            ISSUE_CNT <= ISSUE_CNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a one-cycle-latency register-file model.
// Honours ALU_ISSUE_CNT_EN to also check the optional issue counter.
module tb_alu_issue_ctrl;

    logic        CLK;
    logic        RST;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [31:0] INSTR;
    logic        RF_SEL;
    logic [4:0]  RF_RADDR;
    logic [31:0] RF_RDATA;
    logic [11:0] ALU_CTRL;
    logic [31:0] ALU_OP1;
    logic [31:0] ALU_OP2;
    logic [31:0] ALU_MSG1;
    logic [31:0] ALU_MSG2;
    logic        ALU_ISSUE;
    logic        ALU_ZF;
    logic        RES_VALID;
    logic        BR_TAKEN;
`ifdef ALU_ISSUE_CNT_EN
    logic [31:0] ISSUE_CNT;
`endif

    logic [31:0] int_rf [32];
    logic [31:0] fp_rf  [32];

    int vectors;
    int miscompares;

    alu_issue_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .INSTR       (INSTR),
        .RF_SEL      (RF_SEL),
        .RF_RADDR    (RF_RADDR),
        .RF_RDATA    (RF_RDATA),
        .ALU_CTRL    (ALU_CTRL),
        .ALU_OP1     (ALU_OP1),
        .ALU_OP2     (ALU_OP2),
        .ALU_MSG1    (ALU_MSG1),
        .ALU_MSG2    (ALU_MSG2),
        .ALU_ISSUE   (ALU_ISSUE),
        .ALU_ZF      (ALU_ZF),
        .RES_VALID   (RES_VALID),
        .BR_TAKEN    (BR_TAKEN)
`ifdef ALU_ISSUE_CNT_EN
        ,
        .ISSUE_CNT   (ISSUE_CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous register file: data appears the cycle after the address.
    always @(posedge CLK) begin
        RF_RDATA <= RF_SEL ? fp_rf[RF_RADDR] : int_rf[RF_RADDR];
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic zf);
        INSTR       = instr;
        INSTR_VALID = 1'b1;
        ALU_ZF      = zf;
    endtask

    // Drives one instruction through its full schedule and checks every stage.
    task automatic runInstr(input string name, input logic [31:0] instr, input bit dbl, input logic zf,
                            input logic sel, input logic [4:0] ra, input logic [4:0] rb,
                            input logic [11:0] ctrl, input logic [31:0] op1, input logic [31:0] op2,
                            input logic [31:0] msg1, input logic [31:0] msg2, input logic br);
        applyStimulus(instr, zf);
        checkOutput({name, " ready"}, {31'd0, INSTR_READY}, 32'd1);
        tick();
        INSTR_VALID = 1'b0;
        checkOutput({name, " rda addr"}, {26'd0, RF_SEL, RF_RADDR}, {26'd0, sel, ra});
        if (dbl) begin
            tick();
            checkOutput({name, " rda_hi addr"}, {26'd0, RF_SEL, RF_RADDR}, {26'd0, sel, ra + 5'd1});
        end
        tick();
        checkOutput({name, " rdb addr"}, {26'd0, RF_SEL, RF_RADDR}, {26'd0, sel, rb});
        if (dbl) begin
            tick();
            checkOutput({name, " rdb_hi addr"}, {26'd0, RF_SEL, RF_RADDR}, {26'd0, sel, rb + 5'd1});
        end
        tick();
        checkOutput({name, " capb quiet"}, {26'd0, ALU_ISSUE, INSTR_READY, RF_SEL, RF_RADDR[2:0]}, 32'd0);
        tick();
        checkOutput({name, " issue"}, {31'd0, ALU_ISSUE}, 32'd1);
        checkOutput({name, " ctrl"}, {20'd0, ALU_CTRL}, {20'd0, ctrl});
        checkOutput({name, " op1"}, ALU_OP1, op1);
        checkOutput({name, " op2"}, ALU_OP2, op2);
        checkOutput({name, " msg1"}, ALU_MSG1, msg1);
        checkOutput({name, " msg2"}, ALU_MSG2, msg2);
        tick();
        checkOutput({name, " res"}, {30'd0, ALU_ISSUE, RES_VALID}, 32'd1);
        checkOutput({name, " br"}, {31'd0, BR_TAKEN}, {31'd0, br});
        checkOutput({name, " op1 held"}, ALU_OP1, op1);
        tick();
        checkOutput({name, " idle ready"}, {29'd0, INSTR_READY, RES_VALID, BR_TAKEN}, 32'd4);
        checkOutput({name, " idle ctrl"}, {20'd0, ALU_CTRL}, 32'd0);
        checkOutput({name, " idle op2"}, ALU_OP2, 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST         = 1'b1;
        INSTR_VALID = 1'b0;
        INSTR       = 32'd0;
        ALU_ZF      = 1'b0;
        for (int i = 0; i < 32; i++) begin
            int_rf[i] = 32'd0;
            fp_rf[i]  = 32'd0;
        end

        tick();
        tick();
        checkOutput("reset ready", {31'd0, INSTR_READY}, 32'd1);
        checkOutput("reset flags", {29'd0, ALU_ISSUE, RES_VALID, BR_TAKEN}, 32'd0);
        checkOutput("reset ctrl", {20'd0, ALU_CTRL}, 32'd0);
        checkOutput("reset op1", ALU_OP1, 32'd0);
        checkOutput("reset rf", {26'd0, RF_SEL, RF_RADDR}, 32'd0);
        RST = 1'b0;
        tick();

        int_rf[1] = 32'd5;
        int_rf[2] = 32'd7;
        runInstr("add", 32'h00221820, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2,
                 12'b000011_100000, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0);

        int_rf[1] = 32'd10;
        runInstr("addi", 32'h2022FFFC, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2,
                 12'h200, 32'd10, 32'hFFFFFFFC, 32'd0, 32'd0, 1'b0);

        int_rf[0] = 32'd0;
        int_rf[1] = 32'd1;
        runInstr("sll", 32'h000110C0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1,
                 12'b000011_000000, 32'd1, 32'd3, 32'd0, 32'd0, 1'b0);

        int_rf[1] = 32'h0000F0F0;
        runInstr("andi", 32'h30228001, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2,
                 12'h300, 32'h0000F0F0, 32'h00008001, 32'd0, 32'd0, 1'b0);

        runInstr("lui", 32'h3C02ABCD, 1'b0, 1'b0, 1'b0, 5'd0, 5'd2,
                 12'h3C0, 32'd0, 32'h0000ABCD, 32'd0, 32'd0, 1'b0);

        int_rf[9] = 32'h00001234;
        runInstr("beq zf1", 32'h11290010, 1'b0, 1'b1, 1'b0, 5'd9, 5'd9,
                 12'h100, 32'h00001234, 32'h00001234, 32'd0, 32'd0, 1'b1);
        runInstr("beq zf0", 32'h11290010, 1'b0, 1'b0, 1'b0, 5'd9, 5'd9,
                 12'h100, 32'h00001234, 32'h00001234, 32'd0, 32'd0, 1'b0);

        fp_rf[2] = 32'hA0A0A0A0;
        fp_rf[3] = 32'hA1A1A1A1;
        fp_rf[4] = 32'hB0B0B0B0;
        fp_rf[5] = 32'hB1B1B1B1;
        runInstr("add.d", 32'h46241000, 1'b1, 1'b0, 1'b1, 5'd2, 5'd4,
                 12'h440, 32'hA0A0A0A0, 32'hB0B0B0B0, 32'hA1A1A1A1, 32'hB1B1B1B1, 1'b0);

`ifdef ALU_ISSUE_CNT_EN
        checkOutput("issue cnt", ISSUE_CNT, 32'd8);
`endif

        // Reset lands at N+3 while the producer keeps INSTR_VALID asserted.
        int_rf[1] = 32'd5;
        int_rf[2] = 32'd7;
        applyStimulus(32'h00221820, 1'b0);
        tick();
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST         = 1'b0;
        INSTR_VALID = 1'b0;
        checkOutput("rst flags", {28'd0, INSTR_READY, ALU_ISSUE, RES_VALID, BR_TAKEN}, 32'd8);
        checkOutput("rst ctrl", {20'd0, ALU_CTRL}, 32'd0);
        checkOutput("rst ops", ALU_OP1 | ALU_OP2 | ALU_MSG1 | ALU_MSG2, 32'd0);
        checkOutput("rst rf", {26'd0, RF_SEL, RF_RADDR}, 32'd0);
`ifdef ALU_ISSUE_CNT_EN
        checkOutput("rst issue cnt", ISSUE_CNT, 32'd0);
`endif
        tick();
        checkOutput("rst no issue", {30'd0, ALU_ISSUE, RES_VALID}, 32'd0);
        tick();
        checkOutput("rst still quiet", {29'd0, INSTR_READY, ALU_ISSUE, RES_VALID}, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
